// File: rtl/anim_sequencer_pkg.sv
// Shared encodings for the LED animation frame sequencer: playback modes,
// FSM states, LED constants and the frame-advance helper.
package anim_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [6:0] frame;
        dir_e       dir;
    } step_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [6:0] LED_OFF    = 7'b1111111;
    localparam logic [6:0] FRAME_LAST = 7'd127;

    // 20 bits cover the base divider, 3 more cover the speed multiplier.
    localparam int PRESC_W = 23;

    // Next frame/direction for one tick; one-shot termination is handled by the caller.
    function automatic step_t frame_step(input mode_e mode, input logic [6:0] idx, input dir_e dir);
        step_t s;
        s.frame = idx + 7'd1;
        s.dir   = DIR_UP;
        if (mode == MODE_PINGPONG) begin
            if (dir == DIR_UP) begin
                if (idx == FRAME_LAST) begin
                    s.frame = idx - 7'd1;
                    s.dir   = DIR_DOWN;
                end
            end else if (idx == 7'd0) begin
                s.frame = 7'd1;
            end else begin
                s.frame = idx - 7'd1;
                s.dir   = DIR_DOWN;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/anim_sequencer_if.sv
// Bundle of user controls, status and the pattern-decoder bank bus.
interface anim_sequencer_if;
    import anim_sequencer_pkg::*;

    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [2:0] speed;
    logic [3:0] pat_sel;
    logic [6:0] frame_idx;
    logic [3:0] rom_sel;
    logic [6:0] rom_data;
    logic [6:0] led_n;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, mode, speed, pat_sel, rom_data,
        input  frame_idx, rom_sel, led_n, busy, done
    );

    modport slave (
        input  start, stop, mode, speed, pat_sel, rom_data,
        output frame_idx, rom_sel, led_n, busy, done
    );
endinterface

// File: rtl/anim_tick.sv
// Frame prescaler: counts 0..CLK_DIV*(speed_q+1)-1 and pulses tick at the
// terminal count. clear holds/returns the count to zero.
module anim_tick
    import anim_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [2:0] speed_q,
    output logic       tick
);

    localparam logic [PRESC_W-1:0] DIV = PRESC_W'(CLK_DIV);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic [PRESC_W-1:0] term;

    always_comb begin
        term  = DIV * (PRESC_W'(speed_q) + PRESC_W'(1)) - PRESC_W'(1);
        tick  = (cnt_q == term);
        cnt_d = cnt_q + PRESC_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// LED animation frame sequencer: paces the frame index into the pattern
// decoder bank and registers the returned active-low pattern onto the LEDs.
//
// state | meaning
// IDLE  | LEDs off, frame_idx held at 0, prescaler cleared
// RUN   | frames advance on each prescaler tick per latched mode
module anim_sequencer
    import anim_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 1_000_000,
    parameter int NUM_PAT = 16
) (
    input  logic              clk,
    input  logic              rst,
    anim_sequencer_if.slave   bus
);

    logic [0:0] state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [2:0] speed_q, speed_d;
    logic [3:0] rom_sel_q, rom_sel_d;
    logic [6:0] frame_q, frame_d;
    logic [6:0] led_n_q, led_n_d;
    dir_e       dir_q, dir_d;
    logic       done_q, done_d;

    logic       run;
    logic       clear;
    logic       tick;
    logic [3:0] sel_clamped;
    step_t      step;

    assign run   = (state_q == ST_RUN);
    // Restart/abort must also restart the frame period, not just the index.
    assign clear = !run || bus.start || bus.stop;

    assign sel_clamped = ({1'b0, bus.pat_sel} >= 5'(NUM_PAT)) ? 4'(NUM_PAT - 1) : bus.pat_sel;

    anim_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .speed_q (speed_q),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        speed_d   = speed_q;
        rom_sel_d = rom_sel_q;
        frame_d   = frame_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        step      = frame_step(mode_q, frame_q, dir_q);
        led_n_d   = run ? bus.rom_data : LED_OFF;

        if (bus.stop) begin
            state_d = ST_IDLE;
            frame_d = '0;
            dir_d   = DIR_UP;
        end else if (bus.start) begin
            state_d   = ST_RUN;
            mode_d    = mode_e'(bus.mode);
            speed_d   = bus.speed;
            rom_sel_d = sel_clamped;
            frame_d   = '0;
            dir_d     = DIR_UP;
        end else if (run && tick) begin
            if (mode_q == MODE_ONESHOT && frame_q == FRAME_LAST) begin
                state_d = ST_IDLE;
                frame_d = '0;
                dir_d   = DIR_UP;
                done_d  = 1'b1;
            end else begin
                frame_d = step.frame;
                dir_d   = step.dir;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_LOOP;
            speed_q   <= '0;
            rom_sel_q <= '0;
            frame_q   <= '0;
            dir_q     <= DIR_UP;
            led_n_q   <= LED_OFF;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            rom_sel_q <= rom_sel_d;
            frame_q   <= frame_d;
            dir_q     <= dir_d;
            led_n_q   <= led_n_d;
            done_q    <= done_d;
        end
    end

    assign bus.frame_idx = frame_q;
    assign bus.rom_sel   = rom_sel_q;
    assign bus.led_n     = led_n_q;
    assign bus.busy      = run;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: a vector table plus directed and random sequences,
// all checked against a model that derives the frame from elapsed cycles.
module tb_anim_sequencer;
    import anim_sequencer_pkg::*;

    localparam int DIV  = 4;
    localparam int NPAT = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    anim_sequencer_if bus();

    anim_sequencer #(
        .CLK_DIV (DIV),
        .NUM_PAT (NPAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = ~bus.frame_idx;

    int total = 0;
    int bad   = 0;

    // Model: playback position is just the number of edges since start.
    bit         m_run  = 1'b0;
    bit         m_done = 1'b0;
    int         m_t    = 0;
    int         m_p    = DIV;
    int         m_mode = 0;
    int         m_sel  = 0;
    logic [6:0] m_led  = 7'h7F;

    typedef struct {
        bit         s;
        bit         p;
        int         md;
        int         sp;
        int         ps;
        bit         e_busy;
        int         e_frame;
        int         e_sel;
        logic [6:0] e_led;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [6:0] exp_idx();
        int k;
        if (!m_run) return 7'd0;
        k = m_t / m_p;
        if (m_mode == 2) begin
            k = k % 254;
            return 7'((k <= 127) ? k : 254 - k);
        end
        return 7'(k % 128);
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_t = 0; m_p = DIV; m_mode = 0; m_sel = 0; m_led = 7'h7F;
    endtask

    task automatic model_edge(input bit s, input bit p, input int md, input int sp, input int ps);
        m_led  = m_run ? ~exp_idx() : 7'h7F;
        m_done = 0;
        if (p) begin
            m_run = 0;
        end else if (s) begin
            m_run  = 1;
            m_t    = 0;
            m_mode = md;
            m_p    = DIV * (sp + 1);
            m_sel  = (ps >= NPAT) ? NPAT - 1 : ps;
        end else if (m_run) begin
            m_t++;
            if (m_mode == 1 && m_t == 128 * m_p) begin
                m_run  = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        check("frame_idx", int'(bus.frame_idx), int'(exp_idx()));
        check("busy", int'(bus.busy), int'(m_run));
        check("done", int'(bus.done), int'(m_done));
        check("led_n", int'(bus.led_n), int'(m_led));
        check("rom_sel", int'(bus.rom_sel), m_sel);
    endtask

    task automatic cycle(input bit s, input bit p, input int md, input int sp, input int ps);
        bus.start   = s;
        bus.stop    = p;
        bus.mode    = 2'(md);
        bus.speed   = 3'(sp);
        bus.pat_sel = 4'(ps);
        @(posedge clk);
        #1;
        model_edge(s, p, md, sp, ps);
        check_all();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    // Free-running cycles with the idle control inputs scrambled.
    task automatic idle_rand(input int n, output int dn);
        dn = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(15)));
            if (bus.done) dn++;
        end
    endtask

    initial begin
        int dn;
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.speed = 0; bus.pat_sel = 0;

        vecs[0]  = '{0, 0, 0, 0, 0,  0, 0, 0,  7'h7F};
        vecs[1]  = '{1, 0, 0, 0, 5,  1, 0, 5,  7'h7F};
        vecs[2]  = '{0, 0, 0, 0, 0,  1, 0, 5,  7'h7F};
        vecs[3]  = '{0, 0, 0, 0, 0,  1, 0, 5,  7'h7F};
        vecs[4]  = '{0, 0, 0, 0, 0,  1, 0, 5,  7'h7F};
        vecs[5]  = '{0, 0, 0, 0, 0,  1, 1, 5,  7'h7F};
        vecs[6]  = '{0, 0, 0, 0, 0,  1, 1, 5,  7'h7E};
        vecs[7]  = '{1, 1, 1, 0, 15, 0, 0, 5,  7'h7E};
        vecs[8]  = '{0, 0, 0, 0, 0,  0, 0, 5,  7'h7F};
        vecs[9]  = '{1, 0, 2, 0, 15, 1, 0, 11, 7'h7F};
        vecs[10] = '{0, 1, 0, 0, 0,  0, 0, 11, 7'h7F};
        vecs[11] = '{0, 0, 0, 0, 0,  0, 0, 11, 7'h7F};
        vecs[12] = '{1, 0, 0, 7, 12, 1, 0, 11, 7'h7F};
        vecs[13] = '{1, 0, 0, 0, 10, 1, 0, 10, 7'h7F};
        vecs[14] = '{0, 1, 0, 0, 0,  0, 0, 10, 7'h7F};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        idle_rand(20, dn);

        foreach (vecs[i]) begin
            cycle(vecs[i].s, vecs[i].p, vecs[i].md, vecs[i].sp, vecs[i].ps);
            check("vec_busy", int'(bus.busy), int'(vecs[i].e_busy));
            check("vec_frame", int'(bus.frame_idx), vecs[i].e_frame);
            check("vec_sel", int'(bus.rom_sel), vecs[i].e_sel);
            check("vec_led", int'(bus.led_n), int'(vecs[i].e_led));
        end

        // loop wrap 127 -> 0
        cycle(1, 0, 0, 0, 7);
        idle_rand(130 * DIV, dn);
        cycle(0, 1, 0, 0, 0);

        // one-shot at speed 1
        cycle(1, 0, 1, 1, 3);
        idle_rand(128 * 2 * DIV + 4, dn);
        check("oneshot_done_count", dn, 1);
        check("oneshot_busy_after", int'(bus.busy), 0);
        check("oneshot_led_after", int'(bus.led_n), 'h7F);

        // ping-pong, more than one full bounce
        cycle(1, 0, 2, 0, 9);
        idle_rand(300 * DIV, dn);
        cycle(0, 1, 0, 0, 0);

        // restart mid-frame at frame 50
        cycle(1, 0, 0, 0, 2);
        idle_rand(50 * DIV + 1, dn);
        check("pre_restart_frame", int'(bus.frame_idx), 50);
        cycle(1, 0, 0, 0, 2);
        idle_rand(3 * DIV, dn);
        cycle(0, 1, 0, 0, 0);

        // async reset mid-frame at frame 30
        cycle(1, 0, 2, 0, 8);
        idle_rand(30 * DIV + 2, dn);
        check("pre_reset_frame", int'(bus.frame_idx), 30);
        rst = 1'b1;
        #2;
        check("rst_frame", int'(bus.frame_idx), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_led", int'(bus.led_n), 'h7F);
        check("rst_sel", int'(bus.rom_sel), 0);
        check("rst_done", int'(bus.done), 0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        idle_rand(5, dn);

        // random start/stop traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(59) == 0), ($urandom_range(199) == 0),
                  int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Frame sequencer for the LED animation pattern ROMs. It generates the 7-bit frame index that addresses the selected 128-frame pattern decoder, paces frames with a programmable prescaler, and supports loop, one-shot and ping-pong playback. It registers the returned active-low 7-LED pattern onto the board LEDs. It sits between the user controls (buttons/switches) and the bank of combinational pattern decoders.

## Interface

Parameters:
- CLK_DIV, 1_000_000, base clock cycles per frame at speed 0; must be ≥ 2.
- NUM_PAT, 16, number of pattern decoders in the bank; pat_sel values ≥ NUM_PAT are clamped to NUM_PAT-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; (re)starts playback from frame 0.
- stop  in  1  one-cycle pulse; aborts playback, returns to IDLE.
- mode  in  2  0 = loop, 1 = one-shot, 2 = ping-pong, 3 = treated as loop.
- speed  in  3  frame period = CLK_DIV × (speed+1) cycles.
- pat_sel  in  4  pattern to play.
- frame_idx  out  7  index to pattern decoder bank.
- rom_sel  out  4  decoder select to bank mux.
- rom_data  in  7  combinational pattern from selected decoder (active-low).
- led_n  out  7  registered LED drive, active-low.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at one-shot completion.

## Operation

- FSM states: IDLE, RUN.
- IDLE → RUN on start. At this transition mode, speed and pat_sel are latched into rom_sel/mode_q/speed_q. frame_idx ← 0, direction ← up, prescaler ← 0.
- RUN → IDLE on stop, or at one-shot end.
- start in RUN restarts: re-latch controls, frame_idx ← 0, prescaler ← 0.
- stop and start in the same cycle: stop wins → IDLE.
- Control inputs changing during RUN have no effect until the next start.
- Prescaler: a 20+3-bit counter that counts 0..CLK_DIV×(speed_q+1)−1. It emits a one-cycle tick at the terminal count and wraps to 0.
- On tick, by mode:
  - Loop: frame_idx increments, 127 → 0 wrap.
  - One-shot: frame_idx increments. On the tick at frame 127: done pulses, state → IDLE, frame_idx ← 0.
  - Ping-pong: direction up increments and down decrements. At 127 going up, next frame is 126 and direction ← down. At 0 going down, next frame is 1 and direction ← up. Endpoint frames are never repeated.
- led_n ← rom_data every cycle in RUN. In IDLE, led_n ← 7'b1111111 (all off).

## Timing

- Reset values: state IDLE, frame_idx 0, rom_sel 0, led_n 7'b1111111, busy 0, done 0, prescaler 0, direction up.
- start sampled at edge N: busy = 1 and frame_idx = 0 after edge N; led_n shows frame 0 after edge N+1 (1-cycle latency through the ROM).
- Each frame is displayed for exactly CLK_DIV×(speed_q+1) cycles. The first frame after start has the same length.
- done is high for exactly the one cycle after the edge that leaves RUN in one-shot. busy falls on that same edge.
- stop at edge N: busy = 0 after N; led_n = all-off after N+1.
- rst is honoured at any time, including mid-frame, and forces the reset values immediately.

## Structure

- Shared header/package: mode encodings (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG), LED_OFF = 7'b1111111, FRAME_LAST = 7'd127, state encodings.
- One sub-module, anim_tick: the prescaler. Inputs are clk, rst, clear, speed_q; output is tick; CLK_DIV is a parameter.
- The decoder bank and its pat_sel mux live outside this block.

## Test plan

All scenarios use CLK_DIV = 4 and a behavioural ROM returning {~idx[6:0]}.

- Reset, then idle 20 cycles → led_n = 7'h7F, busy = 0, frame_idx = 0 throughout.
- start, loop, speed = 0 → frame_idx steps every 4 cycles 0,1,…,127,0. led_n tracks ~frame_idx one cycle later.
- start, one-shot, speed = 1 → 8 cycles per frame. After 128×8 cycles, done pulses once, busy falls and led_n = 7'h7F.
- start, ping-pong → sequence …126,127,126,…,1,0,1,2… with no repeated endpoint frame.
- Control-change checks:
  - Change pat_sel/speed mid-run → rom_sel and frame period are unchanged.
  - start mid-run at frame 50 → frame_idx = 0 next cycle and the full frame period restarts.
- Boundary checks:
  - stop and start pulsed in the same cycle → IDLE.
  - rst asserted mid-frame at frame 30 → all outputs take reset values asynchronously.
